// File: rtl/unidad_de_control_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALU select codes and the bundle of control strobes produced every cycle.
package unidad_de_control_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_LDI = 3'b100,
    OP_LD  = 3'b101,
    OP_ST  = 3'b110,
    OP_JZ  = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } estado_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  typedef struct packed {
    logic       carga_ir;
    logic       inc_pc;
    logic       carga_pc;
    logic [1:0] sel_alu;
    logic       sel_inm;
    logic       esc_reg;
    logic       mem_req;
    logic       mem_esc;
  } control_t;

  localparam control_t CONTROL_NULO = '0;

  function automatic logic es_op_alu(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [1:0] alu_de_opcode(input opcode_t op);
    logic [1:0] sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      default: sel = ALU_PASS_B;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/unidad_de_control_if.sv
// Signal bundle between the control unit (master) and the datapath/IR/memory
// side (slave). Field names follow the instruction-register conventions.
interface unidad_de_control_if #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
);

  logic [2:0]          i_Instruccion;
  logic [2*REG_W-1:0]  i_Operandos;
  logic [DATA_W-1:0]   i_Direccionamiento_inmediato;
  logic                i_Bandera_cero;
  logic                i_Mem_Listo;

  logic                o_Carga_IR;
  logic                o_Inc_PC;
  logic                o_Carga_PC;
  logic [1:0]          o_Sel_ALU;
  logic                o_Sel_Inm;
  logic                o_Esc_Reg;
  logic [REG_W-1:0]    o_Dir_RA;
  logic [REG_W-1:0]    o_Dir_RB;
  logic [DATA_W-1:0]   o_Dato_Inm;
  logic                o_Mem_Req;
  logic                o_Mem_Esc;
  logic                o_Error;

  modport master (
    input  i_Instruccion, i_Operandos, i_Direccionamiento_inmediato,
           i_Bandera_cero, i_Mem_Listo,
    output o_Carga_IR, o_Inc_PC, o_Carga_PC, o_Sel_ALU, o_Sel_Inm, o_Esc_Reg,
           o_Dir_RA, o_Dir_RB, o_Dato_Inm, o_Mem_Req, o_Mem_Esc, o_Error
  );

  modport slave (
    output i_Instruccion, i_Operandos, i_Direccionamiento_inmediato,
           i_Bandera_cero, i_Mem_Listo,
    input  o_Carga_IR, o_Inc_PC, o_Carga_PC, o_Sel_ALU, o_Sel_Inm, o_Esc_Reg,
           o_Dir_RA, o_Dir_RB, o_Dato_Inm, o_Mem_Req, o_Mem_Esc, o_Error
  );

endinterface

// File: rtl/unidad_de_control_contador_espera_mem.sv
// Memory wait counter: cleared outside MEM, counts MEM cycles and flags the
// cycle in which the MEM_TIMEOUT-th wait cycle is being spent.
module contador_espera_mem #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cuenta;

  // Saturates at the limit so a stalled FSM can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (clear) begin
      cuenta <= '0;
    end else if (enable && !timeout) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign timeout = (cuenta >= LIMITE);

endmodule

// File: rtl/unidad_de_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC plus MEM/WB for loads and stores,
// with instruction fields latched at the end of DECODE and a sticky timeout flag.
module unidad_de_control
  import unidad_de_control_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  i_Timming,
  input  logic                  i_Rst,
  unidad_de_control_if.master   bus
);

  estado_t             estado_q;
  estado_t             estado_d;
  opcode_t             op_q;
  logic [REG_W-1:0]    ra_q;
  logic [REG_W-1:0]    rb_q;
  logic [DATA_W-1:0]   imm_q;
  logic                error_q;
  logic                fija_error;
  logic                timeout;
  logic                en_mem;
  control_t            ctl;

  assign en_mem = (estado_q == ST_MEM);

  contador_espera_mem #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_contador (
    .clk     (i_Timming),
    .rst_n   (i_Rst),
    .clear   (!en_mem),
    .enable  (en_mem),
    .timeout (timeout)
  );

  always_ff @(posedge i_Timming or negedge i_Rst) begin
    if (!i_Rst) begin
      estado_q <= ST_FETCH;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Fields are captured only on the DECODE->next edge so later IR traffic is ignored.
  always_ff @(posedge i_Timming or negedge i_Rst) begin
    if (!i_Rst) begin
      op_q  <= OP_NOP;
      ra_q  <= '0;
      rb_q  <= '0;
      imm_q <= '0;
    end else if (estado_q == ST_DECODE) begin
      op_q  <= opcode_t'(bus.i_Instruccion);
      ra_q  <= bus.i_Operandos[2*REG_W-1:REG_W];
      rb_q  <= bus.i_Operandos[REG_W-1:0];
      imm_q <= bus.i_Direccionamiento_inmediato;
    end
  end

  always_ff @(posedge i_Timming or negedge i_Rst) begin
    if (!i_Rst) begin
      error_q <= 1'b0;
    end else if (fija_error) begin
      error_q <= 1'b1;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    ctl        = CONTROL_NULO;
    fija_error = 1'b0;
    case (estado_q)
      ST_FETCH: begin
        ctl.carga_ir = 1'b1;
        ctl.inc_pc   = 1'b1;
        estado_d     = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode_t'(bus.i_Instruccion))
          OP_NOP:        estado_d = ST_FETCH;
          OP_LD, OP_ST:  estado_d = ST_MEM;
          default:       estado_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (es_op_alu(op_q)) begin
          ctl.sel_alu = alu_de_opcode(op_q);
          ctl.esc_reg = 1'b1;
        end else if (op_q == OP_LDI) begin
          ctl.sel_alu = ALU_PASS_B;
          ctl.sel_inm = 1'b1;
          ctl.esc_reg = 1'b1;
        end else if (op_q == OP_JZ) begin
          // The zero flag is the only input allowed to reach an output directly.
          ctl.carga_pc = bus.i_Bandera_cero;
        end
        estado_d = ST_FETCH;
      end
      ST_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.mem_esc = (op_q == OP_ST);
        if (bus.i_Mem_Listo) begin
          estado_d = (op_q == OP_LD) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          fija_error = 1'b1;
          estado_d   = ST_FETCH;
        end
      end
      ST_WB: begin
        ctl.sel_alu = ALU_PASS_B;
        ctl.esc_reg = 1'b1;
        estado_d    = ST_FETCH;
      end
      default: begin
        estado_d = ST_FETCH;
      end
    endcase
  end

  // Strobes are gated by reset so everything reads zero while reset is held.
  assign bus.o_Carga_IR = ctl.carga_ir & i_Rst;
  assign bus.o_Inc_PC   = ctl.inc_pc   & i_Rst;
  assign bus.o_Carga_PC = ctl.carga_pc & i_Rst;
  assign bus.o_Sel_ALU  = ctl.sel_alu  & {2{i_Rst}};
  assign bus.o_Sel_Inm  = ctl.sel_inm  & i_Rst;
  assign bus.o_Esc_Reg  = ctl.esc_reg  & i_Rst;
  assign bus.o_Mem_Req  = ctl.mem_req  & i_Rst;
  assign bus.o_Mem_Esc  = ctl.mem_esc  & i_Rst;
  assign bus.o_Dir_RA   = ra_q;
  assign bus.o_Dir_RB   = rb_q;
  assign bus.o_Dato_Inm = imm_q;
  assign bus.o_Error    = error_q;

endmodule

// File: tb/tb_unidad_de_control.sv
// Directed bench for unidad_de_control: walks every opcode class, the memory
// handshake with and without ack, the timeout path and an asynchronous reset.
module tb_unidad_de_control;
  import unidad_de_control_pkg::*;

  localparam int MEM_TIMEOUT = 15;

  // Control vector layout: {IR, INC, PC, ALU[1:0], INM, ESC, REQ, MESC, ERR}
  localparam logic [9:0] V_NONE  = 10'b00_0_00_0_0_0_0_0;
  localparam logic [9:0] V_FETCH = 10'b11_0_00_0_0_0_0_0;
  localparam logic [9:0] V_ADD   = 10'b00_0_00_0_1_0_0_0;
  localparam logic [9:0] V_SUB   = 10'b00_0_01_0_1_0_0_0;
  localparam logic [9:0] V_AND   = 10'b00_0_10_0_1_0_0_0;
  localparam logic [9:0] V_LDI   = 10'b00_0_11_1_1_0_0_0;
  localparam logic [9:0] V_JZ    = 10'b00_1_00_0_0_0_0_0;
  localparam logic [9:0] V_LDMEM = 10'b00_0_00_0_0_1_0_0;
  localparam logic [9:0] V_STMEM = 10'b00_0_00_0_0_1_1_0;
  localparam logic [9:0] V_WB    = 10'b00_0_11_0_1_0_0_0;
  localparam logic [9:0] V_ERR   = 10'b00_0_00_0_0_0_0_1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  unidad_de_control_if #(.DATA_W(8), .REG_W(3)) bus ();

  unidad_de_control #(
    .DATA_W      (8),
    .REG_W       (3),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .i_Timming (clk),
    .i_Rst     (rst_n),
    .bus       (bus)
  );

  logic [9:0]  ctrl;
  logic [13:0] campos;

  assign ctrl = {bus.o_Carga_IR, bus.o_Inc_PC, bus.o_Carga_PC, bus.o_Sel_ALU,
                 bus.o_Sel_Inm, bus.o_Esc_Reg, bus.o_Mem_Req, bus.o_Mem_Esc,
                 bus.o_Error};
  assign campos = {bus.o_Dir_RA, bus.o_Dir_RB, bus.o_Dato_Inm};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [5:0] operandos,
                               input logic [7:0] inm);
    bus.i_Instruccion                = op;
    bus.i_Operandos                  = operandos;
    bus.i_Direccionamiento_inmediato = inm;
  endtask

  task automatic tic();
    @(posedge clk);
    #1;
  endtask

  task automatic expectCycle(input string tag, input logic [9:0] v);
    checkOutput(tag, 32'(ctrl), 32'(v));
    tic();
  endtask

  task automatic runThreeCycle(input string tag, input logic [2:0] op,
                               input logic [5:0] operandos, input logic [7:0] inm,
                               input logic [9:0] v_exec);
    applyStimulus(op, operandos, inm);
    expectCycle({tag, "_fetch"}, V_FETCH);
    expectCycle({tag, "_decode"}, V_NONE);
    expectCycle({tag, "_exec"}, v_exec);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(OP_ADD, 6'b111_111, 8'hFF);
    bus.i_Bandera_cero = 1'b1;
    bus.i_Mem_Listo    = 1'b1;
    #12;
    checkOutput("reset_ctrl", 32'(ctrl), 32'(V_NONE));
    checkOutput("reset_fields", 32'(campos), 32'h0);
    #10;
    rst_n = 1'b1;
    #1;

    // ALU class: exactly three cycles each, ack line high but ignored
    runThreeCycle("add", OP_ADD, 6'b001_010, 8'h00, V_ADD);
    checkOutput("add_ra", 32'(bus.o_Dir_RA), 32'd1);
    checkOutput("add_rb", 32'(bus.o_Dir_RB), 32'd2);
    runThreeCycle("sub", OP_SUB, 6'b111_000, 8'h00, V_SUB);
    checkOutput("sub_ra", 32'(bus.o_Dir_RA), 32'd7);
    runThreeCycle("and", OP_AND, 6'b010_101, 8'h00, V_AND);
    checkOutput("and_rb", 32'(bus.o_Dir_RB), 32'd5);

    // LDI with the IR changing under EXEC
    applyStimulus(OP_LDI, 6'b011_000, 8'hCE);
    expectCycle("ldi_fetch", V_FETCH);
    expectCycle("ldi_decode", V_NONE);
    applyStimulus(OP_NOP, 6'b000_000, 8'h11);
    checkOutput("ldi_imm", 32'(bus.o_Dato_Inm), 32'hCE);
    expectCycle("ldi_exec", V_LDI);
    checkOutput("ldi_imm_hold", 32'(bus.o_Dato_Inm), 32'hCE);

    // NOP: two cycles, latches the new immediate
    expectCycle("nop_fetch", V_FETCH);
    expectCycle("nop_decode", V_NONE);
    checkOutput("nop_latch", 32'(bus.o_Dato_Inm), 32'h11);

    runThreeCycle("jz_taken", OP_JZ, 6'b000_000, 8'h0F, V_JZ);
    checkOutput("jz_imm", 32'(bus.o_Dato_Inm), 32'h0F);
    bus.i_Bandera_cero = 1'b0;
    runThreeCycle("jz_not", OP_JZ, 6'b000_000, 8'h0F, V_NONE);

    // LD with three wait cycles then write-back
    bus.i_Mem_Listo = 1'b0;
    applyStimulus(OP_LD, 6'b101_000, 8'h00);
    expectCycle("ld_fetch", V_FETCH);
    expectCycle("ld_decode", V_NONE);
    for (int k = 0; k < 3; k++) expectCycle("ld_wait", V_LDMEM);
    checkOutput("ld_ra", 32'(bus.o_Dir_RA), 32'd5);
    bus.i_Mem_Listo = 1'b1;
    expectCycle("ld_ack", V_LDMEM);
    bus.i_Mem_Listo = 1'b0;
    expectCycle("ld_wb", V_WB);

    // ST acknowledged on its first MEM cycle: no write-back
    bus.i_Mem_Listo = 1'b1;
    applyStimulus(OP_ST, 6'b110_001, 8'h00);
    expectCycle("st_fetch", V_FETCH);
    expectCycle("st_decode", V_NONE);
    expectCycle("st_mem", V_STMEM);
    bus.i_Mem_Listo = 1'b0;

    // ST never acknowledged: timeout, sticky error
    applyStimulus(OP_ST, 6'b100_010, 8'h00);
    expectCycle("sto_fetch", V_FETCH);
    expectCycle("sto_decode", V_NONE);
    for (int k = 0; k < MEM_TIMEOUT; k++) expectCycle("sto_wait", V_STMEM);
    applyStimulus(OP_NOP, 6'b000_000, 8'h00);
    expectCycle("sto_err_fetch", V_FETCH | V_ERR);
    expectCycle("nop_err_decode", V_ERR);

    // Reset asserted in the middle of MEM
    applyStimulus(OP_ST, 6'b001_011, 8'h5A);
    expectCycle("rst_fetch", V_FETCH | V_ERR);
    expectCycle("rst_decode", V_ERR);
    expectCycle("rst_mem0", V_STMEM | V_ERR);
    checkOutput("rst_mem1", 32'(ctrl), 32'(V_STMEM | V_ERR));
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_ctrl", 32'(ctrl), 32'(V_NONE));
    checkOutput("rst_mid_fields", 32'(campos), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    expectCycle("post_rst_fetch", V_FETCH);
    checkOutput("post_rst_decode", 32'(ctrl), 32'(V_NONE));

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
